// File: rtl/multicycle_adder_pkg.sv
// -----------------------------------------------------------------------------
// mcadd_pkg
//
// Shared definitions for the multi-cycle adder/subtractor:
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - DEF_WIDTH   : default operand/result width
//   - DEF_CHUNK   : default number of bits summed per clock
//   - num_chunks  : number of chunks N = WIDTH / CHUNK
//   - idx_width   : width of the chunk index counter, $clog2(N) with a floor of 1
//
// No ports (package).
// -----------------------------------------------------------------------------
package mcadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index counter width. A single-chunk configuration still gets a
    // 1-bit counter so every signal keeps a legal, non-zero width.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
//
// Purely combinational CHUNK-bit ripple-carry adder built from per-bit
// full-adder equations.
//
// Parameters:
//   CHUNK  - slice width in bits (>= 1)
//
// Ports:
//   x      in  [CHUNK-1:0]  first addend slice
//   y      in  [CHUNK-1:0]  second addend slice (already inverted for subtract)
//   ci     in  1            carry into bit 0
//   s      out [CHUNK-1:0]  slice sum
//   co     out 1            carry out of the top bit
//   c_msb  out 1            carry into the top bit (used for signed overflow)
// -----------------------------------------------------------------------------
module chunk_adder
    import mcadd_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[CHUNK] is the slice carry-out.
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
        assign s[gi]    = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1]  = (x[gi] & y[gi]) | (x[gi] & c[gi]) | (y[gi] & c[gi]);
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//
// Multi-cycle adder/subtractor. Adds (A+B+cin) or subtracts (A+~B+1) two
// WIDTH-bit operands, summing CHUNK bits per clock with a registered carry
// between slices. Latency from accept to out_valid is N = WIDTH/CHUNK cycles;
// peak throughput is one operation per N+2 cycles.
//
// Optional feature (macro MCADD_FLAGS_EN):
//   defined     : ovf = carry-into-MSB XOR cout, zero = (sum == 0), both
//                 registered on entry to DONE.
//   not defined : ovf and zero are tied to 0 and no flag logic exists.
//
// Parameters:
//   WIDTH  - operand/result width; must be a multiple of CHUNK
//   CHUNK  - bits summed per cycle; 1 <= CHUNK <= WIDTH
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands present
//   in_ready   out  1      idle and able to accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add only)
//   sub        in   1      0: A+B+cin, 1: A-B
//   out_valid  out  1      result held and valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (for subtract: 1 = no borrow)
//   ovf        out  1      signed overflow
//   zero       out  1      result is zero
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module multicycle_adder
    import mcadd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int             N        = num_chunks(WIDTH, CHUNK);
    localparam int             IW       = idx_width(WIDTH, CHUNK);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;      // effective B: b, or ~b for subtract
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              cout_q, cout_d;
    logic              in_ready_q;
    logic              out_valid_q;

    // Selected slice and the shared chunk adder's results
    logic [CHUNK-1:0]  x_sel;
    logic [CHUNK-1:0]  y_sel;
    logic [CHUNK-1:0]  s_w;
    logic              co_w;
    logic              c_msb_w;

    logic              accept;
    logic              last_chunk;

    // in_ready_q is only ever high while IDLE, so it doubles as the accept gate.
    assign accept     = in_ready_q & in_valid;
    // The counter never wraps; the final slice is decoded explicitly.
    assign last_chunk = (idx_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // Slice select: one adder, operands muxed by the chunk index
    // -------------------------------------------------------------------------
    always_comb begin
        x_sel = a_q[int'(idx_q) * CHUNK +: CHUNK];
        y_sel = b_q[int'(idx_q) * CHUNK +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x     (x_sel),
        .y     (y_sel),
        .ci    (carry_q),
        .s     (s_w),
        .co    (co_w),
        .c_msb (c_msb_w)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    // Subtract is A + ~B + 1: invert B and seed the carry with 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d[int'(idx_q) * CHUNK +: CHUNK] = s_w;
                carry_d = co_w;
                if (last_chunk) begin
                    cout_d  = co_w;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            // Handshake outputs are registered copies of the next state so
            // that no input reaches an output combinationally.
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Optional status flags
    // -------------------------------------------------------------------------
`ifdef MCADD_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Captured on the final RUN edge, i.e. on entry to DONE: the carry into
    // bit WIDTH-1 comes from the top slice's c_msb, and sum_d is the complete
    // result about to be registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if ((state_q == RUN) && last_chunk) begin
            ovf_q  <= c_msb_w ^ co_w;
            zero_q <= (sum_d == '0);
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    // Carry into the MSB is only needed for the overflow flag.
    logic flags_unused;
    assign flags_unused = c_msb_w;

    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//
// Three instances (CHUNK = 8, 32, 1; WIDTH = 32) share one clock. Stimulus
// pushes the expected result of every accepted operation onto a per-instance
// queue; an independent monitor pops and compares whenever out_valid rises.
// The reference model uses plain wide/signed integer arithmetic.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

    localparam int NI = 3;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic int chunk_of(input int i);
        case (i)
            0:       return 8;
            1:       return 32;
            default: return 1;
        endcase
    endfunction

    function automatic int n_of(input int i);
        return 32 / chunk_of(i);
    endfunction

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n_i     [NI];
    logic        in_valid_i  [NI];
    logic        in_ready_w  [NI];
    logic [31:0] a_i         [NI];
    logic [31:0] b_i         [NI];
    logic        cin_i       [NI];
    logic        sub_i       [NI];
    logic        out_valid_w [NI];
    logic        out_ready_i [NI];
    logic [31:0] sum_w       [NI];
    logic        cout_w      [NI];
    logic        ovf_w       [NI];
    logic        zero_w      [NI];

    exp_t sb [NI][$];
    logic seen [NI];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        multicycle_adder #(
            .WIDTH (32),
            .CHUNK (chunk_of(gi))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_i[gi]),
            .in_valid  (in_valid_i[gi]),
            .in_ready  (in_ready_w[gi]),
            .a         (a_i[gi]),
            .b         (b_i[gi]),
            .cin       (cin_i[gi]),
            .sub       (sub_i[gi]),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready_i[gi]),
            .sum       (sum_w[gi]),
            .cout      (cout_w[gi]),
            .ovf       (ovf_w[gi]),
            .zero      (zero_w[gi])
        );
    end

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h required=%h", name, inst, act, req);
        end
    endtask

    // Reference: wide unsigned arithmetic for sum/cout, signed 64-bit for ovf.
    function automatic exp_t model(input logic [31:0] a_v, input logic [31:0] b_v,
                                   input logic cin_v, input logic sub_v);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      r;
        logic [32:0] u;
        sa  = longint'($signed(a_v));
        sbv = longint'($signed(b_v));
        if (sub_v) begin
            e.sum  = a_v - b_v;
            e.cout = (a_v >= b_v);
            r      = sa - sbv;
        end else begin
            u      = {1'b0, a_v} + {1'b0, b_v} + {32'b0, cin_v};
            e.sum  = u[31:0];
            e.cout = u[32];
            r      = sa + sbv + longint'(cin_v);
        end
`ifdef MCADD_FLAGS_EN
        e.ovf  = (r > SMAX) || (r < SMIN);
        e.zero = (e.sum == 32'd0);
`else
        e.ovf  = 1'b0;
        e.zero = 1'b0;
`endif
        e.acc = 0;
        return e;
    endfunction

    // Monitor: one comparison set per rising out_valid.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (out_valid_w[i] && !seen[i]) begin
                seen[i] = 1'b1;
                if (sb[i].size() == 0) begin
                    check("unexpected_output", i, {31'b0, out_valid_w[i]}, 32'd0);
                end else begin
                    e = sb[i].pop_front();
                    check("sum", i, sum_w[i], e.sum);
                    check("cout", i, {31'b0, cout_w[i]}, {31'b0, e.cout});
                    check("ovf", i, {31'b0, ovf_w[i]}, {31'b0, e.ovf});
                    check("zero", i, {31'b0, zero_w[i]}, {31'b0, e.zero});
                    check("latency", i, cyc - e.acc, n_of(i));
                    $display("txn inst=%0d sum=%h cout=%0b ovf=%0b zero=%0b latency=%0d",
                             i, sum_w[i], cout_w[i], ovf_w[i], zero_w[i], cyc - e.acc);
                end
            end
            if (!out_valid_w[i]) seen[i] = 1'b0;
        end
    end

    task automatic wait_ready(input int i, output bit ok);
        int t = 0;
        while (!in_ready_w[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready_w[i];
        if (!ok) check("in_ready_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic do_op(input int i, input logic [31:0] a_v, input logic [31:0] b_v,
                         input logic cin_v, input logic sub_v, input int hold);
        exp_t e;
        bit   ok;
        int   t;
        wait_ready(i, ok);
        if (!ok) return;
        a_i[i] = a_v; b_i[i] = b_v; cin_i[i] = cin_v; sub_i[i] = sub_v;
        in_valid_i[i] = 1'b1;
        e = model(a_v, b_v, cin_v, sub_v);
        e.acc = cyc + 1;
        sb[i].push_back(e);
        @(negedge clk);
        in_valid_i[i] = 1'b0;
        a_i[i] = $urandom; b_i[i] = $urandom;
        cin_i[i] = 1'($urandom); sub_i[i] = 1'($urandom);
        // With no backpressure, assert out_ready early: it must not matter
        // while out_valid is still low.
        out_ready_i[i] = (hold == 0);
        t = 0;
        while (!out_valid_w[i] && t < n_of(i) + 5) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid_w[i]) begin
            check("out_valid_timeout", i, 32'd0, 32'd1);
            out_ready_i[i] = 1'b0;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            in_valid_i[i] = 1'b1;   // must be ignored in DONE
            @(negedge clk);
            check("hold_sum", i, sum_w[i], e.sum);
            check("hold_cout", i, {31'b0, cout_w[i]}, {31'b0, e.cout});
            check("hold_flags", i, {30'b0, ovf_w[i], zero_w[i]}, {30'b0, e.ovf, e.zero});
            check("hold_in_ready", i, {31'b0, in_ready_w[i]}, 32'd0);
            check("hold_out_valid", i, {31'b0, out_valid_w[i]}, 32'd1);
        end
        in_valid_i[i]  = 1'b0;
        out_ready_i[i] = 1'b1;
        @(negedge clk);
        out_ready_i[i] = 1'b0;
        check("idle_in_ready", i, {31'b0, in_ready_w[i]}, 32'd1);
        check("idle_out_valid", i, {31'b0, out_valid_w[i]}, 32'd0);
    endtask

    task automatic check_reset_state(input int i, input string tag);
        check({tag, "_in_ready"}, i, {31'b0, in_ready_w[i]}, 32'd0);
        check({tag, "_out_valid"}, i, {31'b0, out_valid_w[i]}, 32'd0);
        check({tag, "_sum"}, i, sum_w[i], 32'd0);
        check({tag, "_flags"}, i, {29'b0, cout_w[i], ovf_w[i], zero_w[i]}, 32'd0);
    endtask

    // Start an op, then assert reset so it lands on the 2nd RUN edge
    // (the only RUN edge when N = 1).
    task automatic reset_mid_run(input int i);
        bit ok;
        wait_ready(i, ok);
        if (!ok) return;
        a_i[i] = $urandom | 32'h1; b_i[i] = $urandom; cin_i[i] = 1'b1; sub_i[i] = 1'b0;
        in_valid_i[i] = 1'b1;
        @(negedge clk);             // accept edge passed
        in_valid_i[i] = 1'b0;
        if (n_of(i) >= 2) @(negedge clk);
        rst_n_i[i] = 1'b0;
        @(negedge clk);
        check_reset_state(i, "midrun");
        rst_n_i[i] = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", i, {31'b0, in_ready_w[i]}, 32'd1);
        check("post_reset_out_valid", i, {31'b0, out_valid_w[i]}, 32'd0);
        do_op(i, 32'd3, 32'd4, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n_i[i] = 1'b0; in_valid_i[i] = 1'b0; out_ready_i[i] = 1'b0;
            a_i[i] = '0; b_i[i] = '0; cin_i[i] = 1'b0; sub_i[i] = 1'b0;
            seen[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_reset_state(i, "reset");
        for (int i = 0; i < NI; i++) rst_n_i[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check("reset_release_in_ready", i, {31'b0, in_ready_w[i]}, 32'd1);

        // Directed cases on CHUNK = 8
        do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
        do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
        do_op(0, 32'd5,         32'd7,         1'b0, 1'b1, 2);
        do_op(0, 32'd10,        32'd3,         1'b1, 1'b1, 0);   // cin ignored on sub
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        do_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 10);  // backpressure

        // Reset in flight, then a clean op, for every chunk size
        for (int i = 0; i < NI; i++) reset_mid_run(i);

        // Randomized traffic with random backpressure
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 15; n++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom;
                rb = (n % 5 == 0) ? ra : $urandom;   // exercise zero results
                do_op(i, ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
            end
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++) check("scoreboard_empty", i, sb[i].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor for the ALU datapath. Adds or subtracts two WIDTH-bit operands, processing CHUNK bits per clock with a registered carry between chunks. Trades latency for a short carry chain. Valid/ready handshakes on both sides let it sit between the operand-fetch and writeback stages of the multi-cycle ALU.

## Interface
- WIDTH, 32, operand/result width; WIDTH % CHUNK must be 0
- CHUNK, 8, bits summed per cycle; 1 ≤ CHUNK ≤ WIDTH
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- in_valid  in  1  operands present
- in_ready  out  1  block idle and can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used for add only
- sub  in  1  0: A+B+cin; 1: A−B, computed as A+~B+1 with cin ignored
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB; for sub, 1 means no borrow
- ovf  out  1  signed overflow (flag feature)
- zero  out  1  sum == 0 (flag feature)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid=1 latches a, the effective B (b or ~b), and the carry register (cin, or 1 when sub=1).
  - Chunk index is cleared. Next state RUN.
- RUN: each cycle, chunk i (bits i·CHUNK+CHUNK−1 : i·CHUNK) is summed with the carry register.
  - The result is written into the sum register.
  - The chunk carry-out is written back into the carry register.
  - i increments by 1.
  - After chunk N−1, where N = WIDTH/CHUNK, next state is DONE.
  - For the final chunk, the carry into bit WIDTH−1 is also captured, for ovf.
- DONE: out_valid=1. sum, cout, ovf and zero are held stable.
  - out_ready=1 moves to IDLE.
  - in_ready=0 in DONE, so there is no same-cycle accept.
- in_valid and a/b/cin/sub are ignored outside IDLE.
- The chunk index counter uses $clog2(N) bits, with a minimum of 1. It never wraps; the exit at N−1 is decoded.
- CHUNK=WIDTH: a single RUN cycle.
- Reset: rst_n=0 at any edge forces IDLE.
  - Clears sum, cout, ovf, zero, the carry register and the index.
  - Any operation in flight is discarded with no out_valid.
  - Reset values: in_ready=0 during the reset cycle and 1 after it; out_valid=0; sum=0; cout=0; ovf=0; zero=0.

## Timing
- Operands are accepted at edge k, where in_valid & in_ready.
- Chunks are computed at edges k+1 … k+N.
- out_valid rises after edge k+N, giving a latency of N cycles from accept to out_valid.
- out_valid stays high until the edge where out_ready=1. The block is IDLE the following cycle.
- Maximum throughput: one operation per N+2 cycles (accept, N × RUN, DONE).
- All outputs are registered; there is no combinational path from any input to any output.
- out_ready has no effect while out_valid=0.

## Configuration
- MCADD_FLAGS_EN defined: ovf = carry-into-MSB XOR cout; zero = (sum == 0). Both are computed from the registers on entry to DONE.
- Not defined: the ovf and zero ports remain and are tied to 0, and no flag logic is generated. sum and cout are unaffected.

## Structure
- Package mcadd_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the default WIDTH/CHUNK localparams
  - a function returning N and the index width
- Sub-module chunk_adder: purely combinational CHUNK-bit ripple adder.
  - Inputs: x, y, ci. Outputs: s, co, and c_msb (carry into the top bit).
  - Built per-bit from a full-adder equation.
  - Instantiated once and muxed by chunk index.
- The top level holds the FSM, operand/sum/carry registers and handshake logic.

## Test plan
- WIDTH=32, CHUNK=8, add 0x0000_00FF + 0x0000_0001, cin=0:
  - out_valid exactly 4 cycles after accept
  - sum=0x0000_0100, cout=0, zero=0, ovf=0
- Add 0xFFFF_FFFF + 0x0000_0000, cin=1:
  - sum=0, cout=1, zero=1, ovf=0
  - carry ripples across all 4 chunks
- sub=1 with 0x8000_0000 − 0x0000_0001:
  - sum=0x7FFF_FFFF, cout=1, ovf=1
- sub=1 with 5 − 7:
  - sum=0xFFFF_FFFE, cout=0, ovf=0, zero=0
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - sum and flags stable, in_ready=0, new in_valid ignored
  - out_ready=1 → IDLE the next cycle
- Reset mid-RUN: rst_n=0 at the 2nd RUN edge.
  - All outputs 0 and no out_valid
  - A following op 3+4 gives sum=7
  - Repeat with CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
